// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store bus port.
// LSU_MISALIGN_TRAP_EN is consumed by lsu_bus_port.
package lsu_pkg;

  typedef enum logic [2:0] {
    MC_LB  = 3'b000,
    MC_LH  = 3'b001,
    MC_LW  = 3'b010,
    MC_LBU = 3'b011,
    MC_LHU = 3'b100,
    MC_SB  = 3'b101,
    MC_SH  = 3'b110,
    MC_SW  = 3'b111
  } mem_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic is_store(input mem_ctrl_e ctrl);
    return ctrl >= MC_SB;
  endfunction

  function automatic logic [1:0] size(input mem_ctrl_e ctrl);
    logic [1:0] s;
    s = SZ_WORD;
    case (ctrl)
      MC_LB, MC_LBU, MC_SB: s = SZ_BYTE;
      MC_LH, MC_LHU, MC_SH: s = SZ_HALF;
      default:              s = SZ_WORD;
    endcase
    return s;
  endfunction

  // Drop low offset bits below the natural alignment of the access.
  function automatic logic [1:0] align_off(
    input mem_ctrl_e  ctrl,
    input logic [1:0] off
  );
    logic [1:0] o;
    o = off;
    case (size(ctrl))
      SZ_HALF: o = {off[1], 1'b0};
      SZ_WORD: o = 2'b00;
      default: o = off;
    endcase
    return o;
  endfunction

  function automatic logic misaligned(
    input mem_ctrl_e  ctrl,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    case (size(ctrl))
      SZ_HALF: m = off[0];
      SZ_WORD: m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-enable / store-lane generation and load extraction.
// Purely combinational; the offset is already alignment-adjusted.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] st_data,
  output logic [31:0] ld_ext
);

  mem_ctrl_e   mctrl;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  assign mctrl = mem_ctrl_e'(ctrl);

  always_comb begin
    be      = 4'b1111;
    st_data = wdata;
    case (size(mctrl))
      SZ_BYTE: begin
        be      = 4'b0001 << off;
        st_data = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be      = 4'b0011 << {off[1], 1'b0};
        st_data = {2{wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        st_data = wdata;
      end
    endcase
  end

  always_comb begin
    lbyte = rdata[7:0];
    case (off)
      2'd0:    lbyte = rdata[7:0];
      2'd1:    lbyte = rdata[15:8];
      2'd2:    lbyte = rdata[23:16];
      default: lbyte = rdata[31:24];
    endcase
  end

  assign lhalf = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ld_ext = rdata;
    case (mctrl)
      MC_LB:   ld_ext = {{24{lbyte[7]}}, lbyte};
      MC_LBU:  ld_ext = {24'd0, lbyte};
      MC_LH:   ld_ext = {{16{lhalf[15]}}, lhalf};
      MC_LHU:  ld_ext = {16'd0, lhalf};
      default: ld_ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_bus_port.sv
// MEM-stage load/store port: single-outstanding req/gnt/rvalid bus.
// Optional LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module lsu_bus_port
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [2:0]    req_ctrl,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          stall,
  output logic          done,
  output logic [DW-1:0] ld_data,
  output logic          misalign,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_gnt,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata
);

  lsu_state_e    state;
  lsu_state_e    nxt;
  mem_ctrl_e     ctrl_in;
  mem_ctrl_e     ctrl_q;
  logic [1:0]    off_in;
  logic [1:0]    off_q;
  logic [AW-3:0] waddr_q;
  logic [DW-1:0] wdata_q;
  logic          go_trap;
  logic          accept;
  logic [3:0]    be_c;
  logic [DW-1:0] wd_c;
  logic [DW-1:0] ld_c;

  assign ctrl_in = mem_ctrl_e'(req_ctrl);
  assign accept  = (state == ST_IDLE) && req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;

  assign off_in  = req_addr[1:0];
  assign go_trap = misaligned(ctrl_in, req_addr[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (accept) begin
      mis_q <= go_trap;
    end
  end

  assign misalign = done & mis_q;
`else
  assign off_in   = align_off(ctrl_in, req_addr[1:0]);
  assign go_trap  = 1'b0;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt     = state;
    stall   = 1'b0;
    bus_req = 1'b0;
    unique case (state)
      ST_IDLE: begin
        stall = req_valid & ~rst;
        if (req_valid) begin
          nxt = go_trap ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        if (bus_gnt) begin
          nxt = is_store(ctrl_q) ? ST_DONE : ST_RESP;
        end
      end
      ST_RESP: begin
        stall = 1'b1;
        if (bus_rvalid) begin
          nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        nxt = ST_IDLE;
      end
      default: begin
        nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= MC_LB;
      off_q   <= 2'b00;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      ctrl_q  <= ctrl_in;
      off_q   <= off_in;
      waddr_q <= req_addr[AW-1:2];
      wdata_q <= req_wdata;
    end
  end

  lsu_align u_align (
    .ctrl    (ctrl_q),
    .off     (off_q),
    .wdata   (wdata_q),
    .rdata   (bus_rdata),
    .be      (be_c),
    .st_data (wd_c),
    .ld_ext  (ld_c)
  );

  // Only a response seen in RESP updates the load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_data <= '0;
    end else if ((state == ST_RESP) && bus_rvalid) begin
      ld_data <= ld_c;
    end
  end

  assign done      = (state == ST_DONE);
  assign bus_we    = bus_req & is_store(ctrl_q);
  assign bus_addr  = bus_req ? {waddr_q, 2'b00} : '0;
  assign bus_be    = bus_req ? be_c : 4'b0000;
  assign bus_wdata = bus_req ? wd_c : '0;

endmodule

// File: tb/tb_lsu_bus_port.sv
// Self-checking bench for lsu_bus_port with a behavioural access model.
// Honours LSU_MISALIGN_TRAP_EN when defined for the whole build.
module tb_lsu_bus_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] ld_data;
  logic        misalign;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int pass_cnt = 0;
  int total = 0;
  logic [31:0] ld_model = 32'h0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
    int          nreq;
    bit          unstable;
    int          done_cyc;
    logic [31:0] ld;
    logic        mis;
    bit          mis_stray;
    bit          stall_bad;
    bit          early;
  } obs_t;

  lsu_bus_port #(.AW(32), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ctrl   (req_ctrl),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .done       (done),
    .ld_data    (ld_data),
    .misalign   (misalign),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(input logic [2:0] c);
    case (c)
      3'b000, 3'b011, 3'b101: return 1;
      3'b001, 3'b100, 3'b110: return 2;
      default:                return 4;
    endcase
  endfunction

  function automatic int eff_off(input logic [2:0] c, input logic [31:0] a);
    int o;
    o = int'(a[1:0]);
    return o - (o % nbytes(c));
  endfunction

  function automatic logic [31:0] model_ld(
    input logic [2:0]  c,
    input logic [31:0] a,
    input logic [31:0] rd
  );
    int n;
    longint v;
    n = nbytes(c);
    v = longint'(rd >> (8 * eff_off(c, a)));
    v = v & ((longint'(1) << (8 * n)) - 1);
    if ((c == 3'b000 || c == 3'b001) && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] c, input logic [31:0] a);
    int n;
    n = nbytes(c);
    return 4'(((1 << n) - 1) << eff_off(c, a));
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] c, input logic [31:0] wd);
    int n;
    n = nbytes(c);
    if (n == 1) return 32'(wd[7:0]) * 32'h0101_0101;
    if (n == 2) return 32'(wd[15:0]) * 32'h0001_0001;
    return wd;
  endfunction

  task automatic run_access(
    input  logic [2:0]  c,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [31:0] rd,
    input  int          gd,
    input  int          rdl,
    output obs_t        o
  );
    int cyc;
    int gcyc;
    bit fin;
    o = '{default: '0};
    gcyc = 0;
    fin = 0;
    @(posedge clk); #1;
    bus_gnt = 0;
    bus_rvalid = 0;
    req_valid = 1;
    req_ctrl = c;
    req_addr = a;
    req_wdata = wd;
    bus_rdata = rd;
    cyc = 1;
    @(negedge clk);
    if (stall !== 1'b1) o.stall_bad = 1;
    if (done !== 1'b0 || misalign !== 1'b0) o.early = 1;
    while (!fin && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      req_valid = 0;
      bus_gnt = 0;
      bus_rvalid = 0;
      if (bus_req === 1'b1) begin
        if (o.nreq == 0) begin
          o.addr = bus_addr;
          o.be = bus_be;
          o.wd = bus_wdata;
          o.we = bus_we;
        end else if (bus_addr !== o.addr || bus_be !== o.be ||
                     bus_wdata !== o.wd || bus_we !== o.we) begin
          o.unstable = 1;
        end
        if (o.nreq == gd) begin
          bus_gnt = 1;
          gcyc = cyc;
        end
        o.nreq++;
      end
      if (gcyc > 0 && cyc == gcyc + 1 + rdl) bus_rvalid = 1;
      @(negedge clk);
      if (misalign === 1'b1 && done !== 1'b1) o.mis_stray = 1;
      if (done === 1'b1) begin
        o.done_cyc = cyc;
        o.ld = ld_data;
        o.mis = misalign;
        fin = 1;
        if (stall !== 1'b0) o.stall_bad = 1;
      end else if (stall !== 1'b1) begin
        o.stall_bad = 1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    req_valid = 0;
    req_ctrl = 0;
    req_addr = 0;
    req_wdata = 0;
    bus_gnt = 0;
    bus_rvalid = 0;
    bus_rdata = 0;
    #3;
    total++;
    if ({bus_req, bus_we, stall, done, misalign} !== 5'b0)
      $display("FAIL reset_ctl got %b want 00000", {bus_req, bus_we, stall, done, misalign});
    else pass_cnt++;
    total++;
    if (ld_data !== 32'h0) $display("FAIL reset_ld got %h want 0", ld_data);
    else pass_cnt++;
    total++;
    if (bus_be !== 4'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0)
      $display("FAIL reset_bus got be=%h addr=%h wd=%h want zeros", bus_be, bus_addr, bus_wdata);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_lb();
    obs_t o;
    run_access(3'b000, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0, o);
    ld_model = 32'hFFFF_FF80;
    total++;
    if (o.addr !== 32'h1000) $display("FAIL lb_addr got %h want 00001000", o.addr);
    else pass_cnt++;
    total++;
    if (o.be !== 4'b1000 || o.we !== 1'b0) $display("FAIL lb_be got %b/%b want 1000/0", o.be, o.we);
    else pass_cnt++;
    total++;
    if (o.done_cyc !== 4) $display("FAIL lb_latency got %0d want 4", o.done_cyc);
    else pass_cnt++;
    total++;
    if (o.ld !== ld_model) $display("FAIL lb_data got %h want %h", o.ld, ld_model);
    else pass_cnt++;
    total++;
    if (o.stall_bad || o.early) $display("FAIL lb_stall got bad=%0d early=%0d want 0/0", o.stall_bad, o.early);
    else pass_cnt++;
  endtask

  task automatic test_half();
    obs_t o;
    run_access(3'b100, 32'h2002, 32'h0, 32'h9ABC_1234, 0, 1, o);
    total++;
    if (o.be !== 4'b1100) $display("FAIL lhu_be got %b want 1100", o.be);
    else pass_cnt++;
    total++;
    if (o.ld !== 32'h0000_9ABC) $display("FAIL lhu_data got %h want 00009abc", o.ld);
    else pass_cnt++;
    total++;
    if (o.done_cyc !== 5) $display("FAIL lhu_latency got %0d want 5", o.done_cyc);
    else pass_cnt++;
    run_access(3'b001, 32'h2002, 32'h0, 32'h9ABC_1234, 0, 0, o);
    ld_model = 32'hFFFF_9ABC;
    total++;
    if (o.ld !== ld_model) $display("FAIL lh_data got %h want %h", o.ld, ld_model);
    else pass_cnt++;
  endtask

  task automatic test_sb_delay();
    obs_t o;
    run_access(3'b101, 32'h3001, 32'h1234_56A5, 32'h0, 3, 0, o);
    total++;
    if (o.nreq !== 4 || o.unstable) $display("FAIL sb_hold got n=%0d unstable=%0d want 4/0", o.nreq, o.unstable);
    else pass_cnt++;
    total++;
    if (o.be !== 4'b0010 || o.we !== 1'b1) $display("FAIL sb_be got %b/%b want 0010/1", o.be, o.we);
    else pass_cnt++;
    total++;
    if (o.wd !== 32'hA5A5_A5A5) $display("FAIL sb_wdata got %h want a5a5a5a5", o.wd);
    else pass_cnt++;
    total++;
    if (o.done_cyc !== 6 || o.stall_bad) $display("FAIL sb_done got cyc=%0d stall_bad=%0d want 6/0", o.done_cyc, o.stall_bad);
    else pass_cnt++;
    total++;
    if (o.ld !== ld_model) $display("FAIL sb_ld_hold got %h want %h", o.ld, ld_model);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    obs_t o;
    run_access(3'b111, 32'h4000, 32'hDEAD_BEEF, 32'h0, 0, 0, o);
    total++;
    if (o.be !== 4'b1111 || o.wd !== 32'hDEAD_BEEF)
      $display("FAIL sw_bus got be=%b wd=%h want 1111/deadbeef", o.be, o.wd);
    else pass_cnt++;
    total++;
    if (o.done_cyc !== 3) $display("FAIL sw_latency got %0d want 3", o.done_cyc);
    else pass_cnt++;
    run_access(3'b010, 32'h4004, 32'h0, 32'h0BAD_F00D, 1, 1, o);
    ld_model = 32'h0BAD_F00D;
    total++;
    if (o.early || o.done_cyc !== 6) $display("FAIL b2b_lw got early=%0d cyc=%0d want 0/6", o.early, o.done_cyc);
    else pass_cnt++;
    total++;
    if (o.ld !== ld_model || o.addr !== 32'h4004)
      $display("FAIL b2b_data got %h@%h want %h@00004004", o.ld, o.addr, ld_model);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(posedge clk); #1;
    bus_gnt = 0;
    bus_rvalid = 0;
    req_valid = 1;
    req_ctrl = 3'b010;
    req_addr = 32'h6000;
    bus_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 0;
    total++;
    if (bus_req !== 1'b1) $display("FAIL rst_req_pre got %b want 1", bus_req);
    else pass_cnt++;
    rst = 1;
    #1;
    total++;
    if (bus_req !== 1'b0 || stall !== 1'b0)
      $display("FAIL rst_in_req got req=%b stall=%b want 0/0", bus_req, stall);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 0;
    ld_model = 32'h0;
    total++;
    if (ld_data !== 32'h0) $display("FAIL rst_ld_clear got %h want 0", ld_data);
    else pass_cnt++;
    req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    bus_gnt = 1;
    @(posedge clk); #1;
    bus_gnt = 0;
    total++;
    if (stall !== 1'b1 || bus_req !== 1'b0)
      $display("FAIL rst_resp_pre got stall=%b req=%b want 1/0", stall, bus_req);
    else pass_cnt++;
    rst = 1;
    #1;
    total++;
    if (bus_req !== 1'b0 || stall !== 1'b0)
      $display("FAIL rst_in_resp got req=%b stall=%b want 0/0", bus_req, stall);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 0;
    bus_rvalid = 1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
      @(posedge clk); #1;
      bus_rvalid = 0;
    end
    total++;
    if (seen || ld_data !== 32'h0)
      $display("FAIL rst_late_rvalid got done_seen=%0d ld=%h want 0/0", seen, ld_data);
    else pass_cnt++;
  endtask

  task automatic test_misalign();
    obs_t o;
    run_access(3'b010, 32'h5002, 32'h0, 32'h1357_9BDF, 0, 0, o);
`ifdef LSU_MISALIGN_TRAP_EN
    total++;
    if (o.done_cyc !== 2 || o.nreq !== 0)
      $display("FAIL mis_trap got cyc=%0d nreq=%0d want 2/0", o.done_cyc, o.nreq);
    else pass_cnt++;
    total++;
    if (o.mis !== 1'b1 || o.mis_stray) $display("FAIL mis_pulse got %b stray=%0d want 1/0", o.mis, o.mis_stray);
    else pass_cnt++;
    total++;
    if (o.ld !== ld_model) $display("FAIL mis_ld_hold got %h want %h", o.ld, ld_model);
    else pass_cnt++;
`else
    ld_model = 32'h1357_9BDF;
    total++;
    if (o.addr !== 32'h5000 || o.be !== 4'b1111)
      $display("FAIL mis_trunc got %h/%b want 00005000/1111", o.addr, o.be);
    else pass_cnt++;
    total++;
    if (o.mis !== 1'b0 || o.mis_stray) $display("FAIL mis_tied got %b stray=%0d want 0/0", o.mis, o.mis_stray);
    else pass_cnt++;
    total++;
    if (o.ld !== ld_model || o.done_cyc !== 4)
      $display("FAIL mis_load got %h cyc=%0d want %h/4", o.ld, o.done_cyc, ld_model);
    else pass_cnt++;
`endif
  endtask

  task automatic test_random();
    obs_t o;
    logic [2:0]  c;
    logic [31:0] a, wd, rd;
    int gd, rdl, n, exp_cyc;
    bit st, trap;
    for (int k = 0; k < 24; k++) begin
      c = 3'($urandom_range(0, 7));
      a = $urandom;
      wd = $urandom;
      rd = $urandom;
      gd = $urandom_range(0, 3);
      rdl = $urandom_range(0, 2);
      n = nbytes(c);
      st = (c >= 3'b101);
`ifdef LSU_MISALIGN_TRAP_EN
      trap = (int'(a[1:0]) % n) != 0;
`else
      trap = 0;
`endif
      run_access(c, a, wd, rd, gd, rdl, o);
      exp_cyc = trap ? 2 : (st ? 3 + gd : 4 + gd + rdl);
      if (!st && !trap) ld_model = model_ld(c, a, rd);
      total++;
      if (o.done_cyc !== exp_cyc || o.stall_bad || o.early)
        $display("FAIL rnd%0d_timing got cyc=%0d stall_bad=%0d early=%0d want %0d/0/0",
                 k, o.done_cyc, o.stall_bad, o.early, exp_cyc);
      else pass_cnt++;
      total++;
      if (o.ld !== ld_model || o.mis !== trap || o.mis_stray)
        $display("FAIL rnd%0d_result got ld=%h mis=%b want ld=%h mis=%b", k, o.ld, o.mis, ld_model, trap);
      else pass_cnt++;
      if (trap) begin
        total++;
        if (o.nreq !== 0) $display("FAIL rnd%0d_noreq got %0d want 0", k, o.nreq);
        else pass_cnt++;
      end else begin
        total++;
        if (o.addr !== {a[31:2], 2'b00} || o.be !== model_be(c, a) || o.we !== st ||
            o.nreq !== gd + 1 || o.unstable)
          $display("FAIL rnd%0d_bus got %h/%b/%b n=%0d want %h/%b/%b n=%0d",
                   k, o.addr, o.be, o.we, o.nreq, {a[31:2], 2'b00}, model_be(c, a), st, gd + 1);
        else pass_cnt++;
        if (st) begin
          total++;
          if (o.wd !== model_wd(c, wd))
            $display("FAIL rnd%0d_wdata got %h want %h", k, o.wd, model_wd(c, wd));
          else pass_cnt++;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lb();
    test_half();
    test_sb_delay();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
